// File: rtl/teclado_pkg.sv
// Shared definitions for the keypad entry accumulator: command key codes,
// the key-event FSM states and the BCD to 7-segment glyph table.
package teclado_pkg;

    localparam logic [3:0] TECLA_ENTER = 4'hA;
    localparam logic [3:0] TECLA_APAGA = 4'hB;
    localparam logic [3:0] TECLA_LIMPA = 4'hC;

    // Segment pattern that turns every segment off (active-low outputs).
    localparam logic [6:0] SEG_APAGADO = 7'h7F;

    typedef enum logic [1:0] {
        SOLTURA,
        AGUARDA,
        EXECUTA
    } estado_t;

    // Active-low glyphs, segment a in bit 0 through segment g in bit 6.
    // Non-decimal codes never reach the buffer, but map to a dark digit.
    function automatic logic [6:0] bcd_para_7seg(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_APAGADO;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/varredura_display.sv
// Multiplexed 7-segment driver: lights one buffer digit at a time, each for
// SCAN_DIV cycles, and keeps positions beyond the typed digit count dark.
module varredura_display
    import teclado_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [4*NUM_DIGITS-1:0]           buffer_i,
    input  logic [$clog2(NUM_DIGITS+1)-1:0]   digitos_i,
    output logic [6:0]                        seg_o,
    output logic [NUM_DIGITS-1:0]             an_o
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]      cnt_q;
    logic [IDX_W-1:0]      idx_q;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [3:0]            digito;

    // Pick the digit under the scan index and blank it if it was not typed.
    always_comb begin
        digito = buffer_i[4*idx_q +: 4];
        seg_d  = SEG_APAGADO;
        an_d   = '1;
        if (32'(idx_q) < 32'(digitos_i)) begin
            seg_d = bcd_para_7seg(digito);
            an_d  = ~(NUM_DIGITS'(1) << idx_q);
        end
    end

    // Dwell counter, digit index and the registered segment/anode outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            idx_q <= '0;
            seg_q <= SEG_APAGADO;
            an_q  <= '1;
        end else begin
            if (cnt_q == CNT_MAX) begin
                cnt_q <= '0;
                idx_q <= (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign seg_o = seg_q;
    assign an_o  = an_q;

endmodule

// File: rtl/acumulador_de_teclas.sv
// Keypad entry accumulator: turns each held key into one event, builds a BCD
// number from decimal keys, handles enter/backspace/clear and publishes the
// committed number with a one-cycle strobe.
module acumulador_de_teclas
    import teclado_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [3:0]                        tecla_value,
    input  logic                              tecla_valid,
    output logic [4*NUM_DIGITS-1:0]           numero,
    output logic                              numero_valid,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   digitos,
    output logic                              erro,
    output logic [6:0]                        seg,
    output logic [NUM_DIGITS-1:0]             an
);

    localparam int BUF_W = 4 * NUM_DIGITS;
    localparam int DIG_W = $clog2(NUM_DIGITS + 1);

    localparam logic [DIG_W-1:0] MAX_DIG = DIG_W'(NUM_DIGITS);

    estado_t          state_q;
    logic [3:0]       tecla_q;
    logic [BUF_W-1:0] buffer_q, buffer_d;
    logic [BUF_W-1:0] numero_q, numero_d;
    logic [DIG_W-1:0] digitos_q, digitos_d;
    logic             numero_valid_q, numero_valid_d;
    logic             erro_q, erro_d;

    // Outcome of the captured key; only applied while the FSM sits in EXECUTA.
    always_comb begin
        buffer_d       = buffer_q;
        digitos_d      = digitos_q;
        numero_d       = numero_q;
        numero_valid_d = 1'b0;
        erro_d         = 1'b0;
        if (tecla_q <= 4'h9) begin
            if (digitos_q < MAX_DIG) begin
                buffer_d  = (buffer_q << 4) | BUF_W'(tecla_q);
                digitos_d = digitos_q + 1'b1;
            end else begin
                erro_d = 1'b1;
            end
        end else begin
            case (tecla_q)
                TECLA_ENTER: begin
                    if (digitos_q != '0) begin
                        numero_d       = buffer_q;
                        numero_valid_d = 1'b1;
                        buffer_d       = '0;
                        digitos_d      = '0;
                    end else begin
                        erro_d = 1'b1;
                    end
                end
                TECLA_APAGA: begin
                    if (digitos_q != '0) begin
                        buffer_d  = buffer_q >> 4;
                        digitos_d = digitos_q - 1'b1;
                    end
                end
                TECLA_LIMPA: begin
                    buffer_d  = '0;
                    digitos_d = '0;
                end
                default: begin
                end
            endcase
        end
    end

    // Key-event FSM: wait for release, capture the next key, apply it once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= SOLTURA;
            tecla_q        <= '0;
            buffer_q       <= '0;
            digitos_q      <= '0;
            numero_q       <= '0;
            numero_valid_q <= 1'b0;
            erro_q         <= 1'b0;
        end else begin
            numero_valid_q <= 1'b0;
            erro_q         <= 1'b0;
            case (state_q)
                SOLTURA: begin
                    if (!tecla_valid) begin
                        state_q <= AGUARDA;
                    end
                end
                AGUARDA: begin
                    if (tecla_valid) begin
                        tecla_q <= tecla_value;
                        state_q <= EXECUTA;
                    end
                end
                EXECUTA: begin
                    buffer_q       <= buffer_d;
                    digitos_q      <= digitos_d;
                    numero_q       <= numero_d;
                    numero_valid_q <= numero_valid_d;
                    erro_q         <= erro_d;
                    state_q        <= SOLTURA;
                end
                default: begin
                    state_q <= SOLTURA;
                end
            endcase
        end
    end

    varredura_display #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV)
    ) u_varredura (
        .clk       (clk),
        .rst       (rst),
        .buffer_i  (buffer_q),
        .digitos_i (digitos_q),
        .seg_o     (seg),
        .an_o      (an)
    );

    assign numero       = numero_q;
    assign numero_valid = numero_valid_q;
    assign digitos      = digitos_q;
    assign erro         = erro_q;

endmodule

// File: tb/tb_acumulador_de_teclas.sv
// Bench for the keypad accumulator: directed key sequences followed by random
// presses, all checked against a digit-queue model of the entry buffer.
module tb_acumulador_de_teclas;

    localparam int N  = 4;
    localparam int SD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [3:0]    teclaValue = 4'h0;
    logic          teclaValid = 1'b0;
    logic [4*N-1:0] numero;
    logic          numeroValid;
    logic [2:0]    digitos;
    logic          erro;
    logic [6:0]    seg;
    logic [N-1:0]  an;

    int checks   = 0;
    int failures = 0;

    // Model: typed digits in entry order, plus the last committed number.
    int          modelDigits[$];
    logic [15:0] modelNumero = 16'h0000;

    acumulador_de_teclas #(
        .NUM_DIGITS (N),
        .SCAN_DIV   (SD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tecla_value  (teclaValue),
        .tecla_valid  (teclaValid),
        .numero       (numero),
        .numero_valid (numeroValid),
        .digitos      (digitos),
        .erro         (erro),
        .seg          (seg),
        .an           (an)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Single comparison point: counts it and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Standard decimal glyphs written active-high (gfedcba), inverted for the pins.
    function automatic logic [6:0] glyph(input int d);
        logic [6:0] hi;
        case (d)
            0: hi = 7'b0111111;
            1: hi = 7'b0000110;
            2: hi = 7'b1011011;
            3: hi = 7'b1001111;
            4: hi = 7'b1100110;
            5: hi = 7'b1101101;
            6: hi = 7'b1111101;
            7: hi = 7'b0000111;
            8: hi = 7'b1111111;
            9: hi = 7'b1101111;
            default: hi = 7'b0000000;
        endcase
        return ~hi;
    endfunction

    // BCD value of the typed digits, first-typed digit most significant.
    function automatic logic [15:0] packDigits();
        logic [15:0] v = 16'h0000;
        foreach (modelDigits[k]) v = (v << 4) | 16'(modelDigits[k]);
        return v;
    endfunction

    // Reference behaviour of one key event.
    task automatic modelPress(input int key, output int expNv, output int expEr);
        expNv = 0;
        expEr = 0;
        if (key <= 9) begin
            if (modelDigits.size() < N) modelDigits.push_back(key);
            else expEr = 1;
        end else if (key == 10) begin
            if (modelDigits.size() > 0) begin
                modelNumero = packDigits();
                modelDigits.delete();
                expNv = 1;
            end else begin
                expEr = 1;
            end
        end else if (key == 11) begin
            if (modelDigits.size() > 0) void'(modelDigits.pop_back());
        end else if (key == 12) begin
            modelDigits.delete();
        end
    endtask

    // One press: hold the key, swap the code mid-hold, release, check the event.
    task automatic applyStimulus(input logic [3:0] key, input int hold, input int gap,
                                 input logic [3:0] altKey);
        int prevDig = modelDigits.size();
        int expNv, expEr;
        int nvCnt = 0, erCnt = 0, nvAt = -1, erAt = -1;
        modelPress(int'(key), expNv, expEr);
        @(negedge clk);
        teclaValue = key;
        teclaValid = 1'b1;
        for (int s = 1; s <= hold + gap; s++) begin
            @(negedge clk);
            if (s == 1) begin
                checkOutput("digitos_before_update", 32'(digitos), 32'(prevDig));
                teclaValue = altKey;
            end
            if (numeroValid) begin
                nvCnt++;
                if (nvAt < 0) nvAt = s;
            end
            if (erro) begin
                erCnt++;
                if (erAt < 0) erAt = s;
            end
            if (s == hold) teclaValid = 1'b0;
        end
        checkOutput("numero_valid_cycles", 32'(nvCnt), 32'(expNv));
        checkOutput("erro_cycles", 32'(erCnt), 32'(expEr));
        if (expNv == 1) checkOutput("numero_valid_latency", 32'(nvAt), 32'd2);
        if (expEr == 1) checkOutput("erro_latency", 32'(erAt), 32'd2);
        checkOutput("digitos", 32'(digitos), 32'(modelDigits.size()));
        checkOutput("numero", 32'(numero), 32'(modelNumero));
    endtask

    // One full scan period: every lit slot must show the right glyph, blanks
    // must be fully dark, and each typed digit must be lit for SD cycles.
    task automatic checkDisplay();
        int litCnt[N];
        int sz = modelDigits.size();
        logic [N-1:0] oneHot;
        int idx;
        foreach (litCnt[i]) litCnt[i] = 0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < N * SD; s++) begin
            @(negedge clk);
            if (an === 4'hF) begin
                checkOutput("seg_blank", 32'(seg), 32'h7F);
            end else begin
                idx = -1;
                for (int i = 0; i < N; i++) begin
                    oneHot = N'(1) << i;
                    if (an === ~oneHot) idx = i;
                end
                checkOutput("an_lit_is_typed_digit", 32'(idx >= 0 && idx < sz), 32'd1);
                if (idx >= 0 && idx < sz) begin
                    checkOutput("seg_glyph", 32'(seg), 32'(glyph(modelDigits[sz-1-idx])));
                    litCnt[idx]++;
                end
            end
        end
        for (int i = 0; i < N; i++)
            checkOutput("lit_cycles", 32'(litCnt[i]), (i < sz) ? 32'(SD) : 32'd0);
    endtask

    initial begin
        int pulses;
        int waitCnt;
        logic [3:0] k;

        // Reset with a key already held.
        rst = 1'b0;
        teclaValid = 1'b1;
        teclaValue = 4'h5;
        repeat (3) @(negedge clk);
        checkOutput("reset_digitos", 32'(digitos), 32'd0);
        checkOutput("reset_numero", 32'(numero), 32'd0);
        checkOutput("reset_numero_valid", 32'(numeroValid), 32'd0);
        checkOutput("reset_erro", 32'(erro), 32'd0);
        checkOutput("reset_an", 32'(an), 32'hF);
        checkOutput("reset_seg", 32'(seg), 32'h7F);
        rst = 1'b1;
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (numeroValid || erro) pulses++;
        end
        checkOutput("held_key_pulses", 32'(pulses), 32'd0);
        checkOutput("held_key_digitos", 32'(digitos), 32'd0);
        teclaValid = 1'b0;
        @(negedge clk);
        applyStimulus(4'h5, 4, 3, 4'h7);
        applyStimulus(4'hC, 4, 3, 4'h1);

        $display("[TB] entry 1234 then enter");
        applyStimulus(4'h1, 50, 5, 4'h1);
        applyStimulus(4'h2, 50, 5, 4'h2);
        applyStimulus(4'h3, 50, 5, 4'h3);
        applyStimulus(4'h4, 50, 5, 4'h4);
        applyStimulus(4'hA, 50, 5, 4'hA);

        $display("[TB] overflow on fifth digit");
        applyStimulus(4'h1, 5, 2, 4'h9);
        applyStimulus(4'h2, 5, 2, 4'h9);
        applyStimulus(4'h3, 5, 2, 4'h9);
        applyStimulus(4'h4, 5, 2, 4'h9);
        applyStimulus(4'h5, 5, 2, 4'hA);
        checkDisplay();
        applyStimulus(4'hC, 3, 2, 4'h0);

        $display("[TB] backspace and empty commands");
        applyStimulus(4'h7, 3, 2, 4'h0);
        applyStimulus(4'h8, 3, 2, 4'h0);
        applyStimulus(4'hB, 3, 2, 4'h0);
        applyStimulus(4'h9, 3, 2, 4'h0);
        applyStimulus(4'hA, 3, 2, 4'h0);
        applyStimulus(4'hB, 3, 2, 4'h0);
        applyStimulus(4'hA, 3, 2, 4'h0);
        applyStimulus(4'h4, 3, 1, 4'h0);
        applyStimulus(4'h2, 2, 1, 4'h0);
        applyStimulus(4'hC, 2, 1, 4'h0);
        applyStimulus(4'hA, 2, 1, 4'h0);
        applyStimulus(4'hD, 2, 1, 4'h1);
        applyStimulus(4'hE, 2, 1, 4'h2);
        applyStimulus(4'hF, 2, 1, 4'h3);

        $display("[TB] display scan of 42 and reset mid-scan");
        applyStimulus(4'h4, 3, 2, 4'h0);
        applyStimulus(4'h2, 3, 2, 4'h0);
        checkDisplay();
        waitCnt = 0;
        while (an === 4'hF && waitCnt < 2 * N * SD) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("lit_before_reset", 32'(an !== 4'hF), 32'd1);
        #2 rst = 1'b0;
        modelDigits.delete();
        modelNumero = 16'h0000;
        #1;
        checkOutput("async_reset_an", 32'(an), 32'hF);
        checkOutput("async_reset_seg", 32'(seg), 32'h7F);
        checkOutput("async_reset_digitos", 32'(digitos), 32'd0);
        checkOutput("async_reset_numero", 32'(numero), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        $display("[TB] reset during the action cycle");
        applyStimulus(4'h4, 3, 2, 4'h0);
        @(negedge clk);
        teclaValue = 4'h7;
        teclaValid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        modelDigits.delete();
        #1;
        checkOutput("exec_reset_digitos", 32'(digitos), 32'd0);
        pulses = 0;
        repeat (2) begin
            @(negedge clk);
            if (numeroValid || erro) pulses++;
        end
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (numeroValid || erro) pulses++;
        end
        teclaValid = 1'b0;
        @(negedge clk);
        checkOutput("exec_reset_pulses", 32'(pulses), 32'd0);
        checkOutput("exec_reset_digitos_after", 32'(digitos), 32'd0);
        applyStimulus(4'h5, 3, 2, 4'h0);

        $display("[TB] random presses");
        for (int r = 0; r < 80; r++) begin
            k = 4'($urandom_range(0, 15));
            applyStimulus(k, int'($urandom_range(2, 6)), int'($urandom_range(1, 4)),
                          4'($urandom_range(0, 15)));
            if (r % 20 == 19) checkDisplay();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/acumulador_de_teclas.md
# acumulador_de_teclas

Keypad entry accumulator sitting directly downstream of the matrix-keypad decoder: consumes its `tecla_value`/`tecla_valid` pair, turns each held key into exactly one key event, and builds a multi-digit BCD number from decimal keys. Command keys: enter, backspace and clear. The committed number is published with a one-cycle strobe for the rest of the system. The digits being typed are shown on a multiplexed 7-segment display.

## Interface
Parameters:
- `NUM_DIGITS`, default 4: BCD digits in the entry buffer and display digits driven.
- `SCAN_DIV`, default 1000: clock cycles each display digit stays lit.

Ports:
- `clk`  in  1: single clock; all registers on rising edge.
- `rst`  in  1: asynchronous, active-low reset. Asserted low clears all state immediately, independent of `clk`.
- `tecla_value`  in  4: key code from the decoder; meaningful only while `tecla_valid`=1.
- `tecla_valid`  in  1: level signal; high for as long as a debounced key is held.
- `numero`  out  4*NUM_DIGITS: last committed value in BCD, least-significant digit in [3:0].
- `numero_valid`  out  1: one-cycle pulse when `numero` is updated.
- `digitos`  out  $clog2(NUM_DIGITS+1): number of digits currently in the entry buffer.
- `erro`  out  1: one-cycle pulse on a rejected key.
- `seg`  out  7: segments a..g in [0]..[6], active-low.
- `an`  out  NUM_DIGITS: digit enables, active-low, one-hot or all-ones.

## Operation
- FSM states:
  - SOLTURA: waiting for key release.
  - AGUARDA: waiting for a key.
  - EXECUTA: applying the action for the captured key.
- State transitions:
  - Reset state is SOLTURA.
  - SOLTURA: stays while `tecla_valid`=1; goes to AGUARDA when `tecla_valid`=0.
  - AGUARDA: on `tecla_valid`=1, captures `tecla_value` into `tecla_q` and goes to EXECUTA.
  - EXECUTA: always lasts one cycle, then goes to SOLTURA.
  - Consequence: one action per press regardless of hold time. A key already held when reset is released is ignored until it is released.
- Actions in EXECUTA, by `tecla_q`:
  - 0x0–0x9, `digitos`<NUM_DIGITS: buffer <= {buffer, digit}, shifting left by 4; `digitos`++. A leading 0 counts as a digit.
  - 0x0–0x9, buffer full: buffer unchanged, `erro` pulses.
  - 0xA (enter), `digitos`>0: `numero` <= buffer, `numero_valid` pulses, buffer <= 0, `digitos` <= 0.
  - 0xA (enter), `digitos`=0: nothing committed, `erro` pulses.
  - 0xB (backspace): buffer shifts right by 4 and `digitos`--. When `digitos`=0 it is a no-op with no error.
  - 0xC (clear): buffer <= 0, `digitos` <= 0; `numero` is unchanged.
  - 0xD, 0xE, 0xF: ignored, no error.
- Display:
  - A scan counter runs 0..SCAN_DIV-1; on wrap the digit index advances 0..NUM_DIGITS-1 and wraps to 0.
  - Index i drives buffer digit i.
  - If i ≥ `digitos`, the digit is blanked: `an` all ones, `seg` all ones. With an empty buffer the display is fully dark.
  - BCD-to-7-seg uses standard decimal glyphs.

## Timing
- Reset values: state SOLTURA, `numero`=0, `numero_valid`=0, `digitos`=0, `erro`=0, buffer=0, `tecla_q`=0, scan counter and index 0, `an`=all ones, `seg`=all ones.
- Latency: if `tecla_valid` is first sampled high in AGUARDA at edge T, EXECUTA occupies cycle T..T+1. Buffer, `digitos`, `numero`, `numero_valid` and `erro` update at edge T+1.
- `numero_valid`/`erro` are high for exactly cycle T+1..T+2 and then drop.
- `tecla_value` is sampled only at the AGUARDA→EXECUTA edge; changes while the key is held have no effect.
- A release pulse of `tecla_valid` that is low for one cycle is enough to re-arm the FSM.
- All outputs are registered. Display outputs are independent of the FSM; buffer changes appear on the next scan slot of the affected digit.
- Reset asserted mid-EXECUTA: no action is applied and no pulse is emitted.

## Structure
- Package `teclado_pkg`:
  - key constants TECLA_ENTER=4'hA, TECLA_APAGA=4'hB, TECLA_LIMPA=4'hC;
  - state enum {SOLTURA, AGUARDA, EXECUTA};
  - function `bcd_para_7seg`.
- Sub-module `varredura_display`:
  - inputs: buffer, `digitos`;
  - contains the scan counter, digit index, blanking, `seg`/`an` registers;
  - parameterised by NUM_DIGITS, SCAN_DIV.

## Test plan
- Reset released with `tecla_valid`=1, key 0x5 held for 20 cycles, then released → no action, `digitos`=0; the next press of 0x5 gives `digitos`=1.
- Keys 1,2,3,4 (each held 50 cycles, 5 cycles apart), then A → `numero`=16'h1234, `numero_valid` high exactly 1 cycle, `digitos`=0, `erro` never high.
- Keys 1,2,3,4,5 → after the fifth key, buffer 16'h1234, one `erro` pulse, `digitos`=4.
- Keys 7,8,B,9,A → `numero`=16'h0079. Then B on an empty buffer, then A → no change to `numero`, exactly one `erro` pulse (on A).
- Keys 4,2,C,A → `numero` keeps its previous value, one `erro` pulse. D/E/F presses → no output activity.
- SCAN_DIV=4, buffer 2 digits "42" → `an` cycles 1110 (seg=digit 2 glyph), 1101 (glyph 4), 1111, 1111, 4 cycles each. `rst` low mid-scan → `an`/`seg` all ones immediately.
